// File: rtl/matrix_op_sequencer.sv
// Byte-serial front end for the 4x4 element-wise compute units: loads A and B,
// pulses op_start, captures the 16-bit result matrix and streams it back out.
module matrix_op_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  op_start,
    output logic [0:3][0:3][7:0]  op_a,
    output logic [0:3][0:3][7:0]  op_b,
    input  logic [0:3][0:3][15:0] op_c,
    input  logic                  op_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer occurs on a rising edge where valid and ready are
    // both high; ready and valid are decoded from registered state only, so
    // neither side's ready/valid depends combinationally on the other side.

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int              CW      = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic [4:0]            load_cnt_q, load_cnt_d;
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  done_prev_q, done_prev_d;
    logic [0:3][0:3][7:0]  op_a_q, op_a_d;
    logic [0:3][0:3][7:0]  op_b_q, op_b_d;
    logic [0:15][15:0]     res_q, res_d;

    logic in_fire;
    logic out_fire;
    logic done_edge;

    assign in_ready  = (state_q == S_LOAD) && !rst;
    assign op_start  = (state_q == S_START);
    assign busy      = (state_q != S_LOAD);
    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = out_valid ? res_q[idx_q] : 16'd0;
    assign out_last  = out_valid && (idx_q == 4'd15);
    assign err       = err_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign dbg_state = state_q;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    // A done flag that is already high when WAIT begins is not a completion.
    assign done_edge = op_done && !done_prev_q;

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        idx_d       = idx_q;
        err_d       = err_q;
        done_prev_d = op_done;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_d       = res_q;

        case (state_q)
            S_LOAD: begin
                if (in_fire) begin
                    if (load_cnt_q[4]) begin
                        op_b_d[load_cnt_q[3:2]][load_cnt_q[1:0]] = in_data;
                    end else begin
                        op_a_d[load_cnt_q[3:2]][load_cnt_q[1:0]] = in_data;
                    end
                    load_cnt_d = load_cnt_q + 5'd1;
                    if (load_cnt_q == 5'd31) begin
                        load_cnt_d = 5'd0;
                        state_d    = S_START;
                    end
                end
            end
            S_START: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (done_edge) begin
                    res_d   = op_c;
                    state_d = S_DRAIN;
                end else if (wait_cnt_q == TO_LAST) begin
                    // Forced completion: whatever op_c holds is drained anyway.
                    err_d   = 1'b1;
                    res_d   = op_c;
                    state_d = S_DRAIN;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        idx_d   = 4'd0;
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            load_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            done_prev_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            done_prev_q <= done_prev_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_q       <= res_d;
        end
    end

endmodule
